lane_vrf_write_stage: RTL and testbench

- Parametrised lane stage-3 write-back block with NUM_CH enqueue channels (e.g. execute result and cross-lane write).
- Round-robin arbitration selects at most one channel per cycle.
- Computes the VRF address (vd, offset) from the group counter and buffers requests in a DEPTH-entry FIFO feeding the VRF write port.
- Optionally coalesces a new request into the FIFO tail entry when both target the same VRF word.

---
 rtl/lane_vrf_write_stage.sv | 166 ++++++++++++++++
 tb/tb_lane_vrf_write_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_vrf_write_stage.sv
// Lane write-back stage: round-robin arbiter over NUM_CH enqueue channels,
// VRF address generation and a small FIFO (with optional tail coalescing).
module lane_vrf_write_stage #(
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int DEPTH        = 4,
  parameter int GROUP_WIDTH  = 9,
  parameter int OFFSET_WIDTH = 5,
  parameter int VD_WIDTH     = 5,
  parameter int IDX_WIDTH    = 3,
  parameter int NUM_CH       = 2,
  parameter int MERGE_EN     = 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_CH-1:0]                 enq_valid,
  output logic [NUM_CH-1:0]                 enq_ready,
  input  logic [NUM_CH*GROUP_WIDTH-1:0]     enq_groupCounter,
  input  logic [NUM_CH*VD_WIDTH-1:0]        enq_vd,
  input  logic [NUM_CH*DATA_WIDTH-1:0]      enq_data,
  input  logic [NUM_CH*MASK_WIDTH-1:0]      enq_mask,
  input  logic [NUM_CH*IDX_WIDTH-1:0]       enq_instructionIndex,
  input  logic [NUM_CH-1:0]                 enq_last,
  input  logic                              vrfWriteRequest_ready,
  output logic                              vrfWriteRequest_valid,
  output logic [VD_WIDTH-1:0]               vrfWriteRequest_bits_vd,
  output logic [OFFSET_WIDTH-1:0]           vrfWriteRequest_bits_offset,
  output logic [MASK_WIDTH-1:0]             vrfWriteRequest_bits_mask,
  output logic [DATA_WIDTH-1:0]             vrfWriteRequest_bits_data,
  output logic                              vrfWriteRequest_bits_last,
  output logic [IDX_WIDTH-1:0]              vrfWriteRequest_bits_instructionIndex,
  output logic [$clog2(DEPTH+1)-1:0]        occupancy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [VD_WIDTH-1:0]     r_vd   [DEPTH];
  logic [OFFSET_WIDTH-1:0] r_off  [DEPTH];
  logic [MASK_WIDTH-1:0]   r_mask [DEPTH];
  logic [DATA_WIDTH-1:0]   r_data [DEPTH];
  logic                    r_last [DEPTH];
  logic [IDX_WIDTH-1:0]    r_idx  [DEPTH];
  logic [CNT_W-1:0]        r_count;
  logic [PTR_W-1:0]        r_head;
  logic [PTR_W-1:0]        r_tail;
  logic [CH_W-1:0]         r_rr;

  logic [VD_WIDTH-1:0]     w_vd   [NUM_CH];
  logic [OFFSET_WIDTH-1:0] w_off  [NUM_CH];
  logic [MASK_WIDTH-1:0]   w_mask [NUM_CH];
  logic [DATA_WIDTH-1:0]   w_data [NUM_CH];
  logic [IDX_WIDTH-1:0]    w_idx  [NUM_CH];

  logic                    w_cand_found;
  logic [CH_W-1:0]         w_cand;
  logic [CH_W-1:0]         w_rr_next;
  logic [PTR_W-1:0]        w_tail_prev;
  logic                    w_deq_fire;
  logic                    w_merge_hit;
  logic                    w_grant;
  logic                    w_push;
  logic                    w_merge;
  logic [DATA_WIDTH-1:0]   w_merge_data;

  // Per-channel address: high group-counter bits advance the register index.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [GROUP_WIDTH-1:0] w_gc;
    assign w_gc       = enq_groupCounter[gi*GROUP_WIDTH +: GROUP_WIDTH];
    assign w_vd[gi]   = enq_vd[gi*VD_WIDTH +: VD_WIDTH]
                        + VD_WIDTH'(w_gc[GROUP_WIDTH-1:OFFSET_WIDTH]);
    assign w_off[gi]  = w_gc[OFFSET_WIDTH-1:0];
    assign w_mask[gi] = enq_mask[gi*MASK_WIDTH +: MASK_WIDTH];
    assign w_data[gi] = enq_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_idx[gi]  = enq_instructionIndex[gi*IDX_WIDTH +: IDX_WIDTH];
    assign enq_ready[gi] = ~reset & w_grant & (w_cand == CH_W'(gi));
  end

  always_comb begin : p_arb
    logic [CH_W-1:0] v_j;
    v_j          = '0;
    w_cand_found = 1'b0;
    w_cand       = '0;
    // Scan downwards so the channel closest to the pointer wins last.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      v_j = CH_W'((int'(r_rr) + k) % NUM_CH);
      if (enq_valid[v_j]) begin
        w_cand_found = 1'b1;
        w_cand       = v_j;
      end
    end
  end

  assign w_rr_next   = (w_cand == CH_W'(NUM_CH - 1)) ? '0 : w_cand + CH_W'(1);
  assign w_tail_prev = r_tail - PTR_W'(1);
  assign w_deq_fire  = (r_count != '0) & vrfWriteRequest_ready;

  if (MERGE_EN != 0) begin : g_merge
    assign w_merge_hit = (r_count != '0)
                       && (r_vd[w_tail_prev]  == w_vd[w_cand])
                       && (r_off[w_tail_prev] == w_off[w_cand])
                       && (r_idx[w_tail_prev] == w_idx[w_cand])
                       && !r_last[w_tail_prev]
                       && !((r_count == CNT_W'(1)) && w_deq_fire);
  end else begin : g_no_merge
    assign w_merge_hit = 1'b0;
  end

  for (genvar gi = 0; gi < MASK_WIDTH; gi++) begin : g_byte
    assign w_merge_data[gi*8 +: 8] = w_mask[w_cand][gi] ? w_data[w_cand][gi*8 +: 8]
                                                        : r_data[w_tail_prev][gi*8 +: 8];
  end

  assign w_grant = w_cand_found & ((r_count < CNT_W'(DEPTH)) | w_merge_hit);
  assign w_push  = w_grant & ~w_merge_hit;
  assign w_merge = w_grant & w_merge_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_rr    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_vd[i]   <= '0;
        r_off[i]  <= '0;
        r_mask[i] <= '0;
        r_data[i] <= '0;
        r_last[i] <= 1'b0;
        r_idx[i]  <= '0;
      end
    end else begin
      if (w_grant) r_rr <= w_rr_next;
      if (w_push) begin
        r_vd[r_tail]   <= w_vd[w_cand];
        r_off[r_tail]  <= w_off[w_cand];
        r_mask[r_tail] <= w_mask[w_cand];
        r_data[r_tail] <= w_data[w_cand];
        r_last[r_tail] <= enq_last[w_cand];
        r_idx[r_tail]  <= w_idx[w_cand];
        r_tail         <= r_tail + PTR_W'(1);
      end else if (w_merge) begin
        r_mask[w_tail_prev] <= r_mask[w_tail_prev] | w_mask[w_cand];
        r_data[w_tail_prev] <= w_merge_data;
        r_last[w_tail_prev] <= enq_last[w_cand];
      end
      if (w_deq_fire) r_head <= r_head + PTR_W'(1);
      case ({w_push, w_deq_fire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign vrfWriteRequest_valid                 = (r_count != '0);
  assign vrfWriteRequest_bits_vd               = r_vd[r_head];
  assign vrfWriteRequest_bits_offset           = r_off[r_head];
  assign vrfWriteRequest_bits_mask             = r_mask[r_head];
  assign vrfWriteRequest_bits_data             = r_data[r_head];
  assign vrfWriteRequest_bits_last             = r_last[r_head];
  assign vrfWriteRequest_bits_instructionIndex = r_idx[r_head];
  assign occupancy                             = r_count;

endmodule

// File: tb/tb_lane_vrf_write_stage.sv
// Directed bench for lane_vrf_write_stage with default parameters.
module tb_lane_vrf_write_stage;

  logic        clk;
  logic        rst;
  logic [1:0]  enq_valid;
  logic [1:0]  enq_ready;
  logic [17:0] enq_gc;
  logic [9:0]  enq_vd;
  logic [63:0] enq_data;
  logic [7:0]  enq_mask;
  logic [5:0]  enq_idx;
  logic [1:0]  enq_last;
  logic        rd_ready;
  logic        out_valid;
  logic [4:0]  out_vd;
  logic [4:0]  out_off;
  logic [3:0]  out_mask;
  logic [31:0] out_data;
  logic        out_last;
  logic [2:0]  out_idx;
  logic [2:0]  occ;

  int checks   = 0;
  int failures = 0;

  lane_vrf_write_stage dut (
    .clock                                 (clk),
    .reset                                 (rst),
    .enq_valid                             (enq_valid),
    .enq_ready                             (enq_ready),
    .enq_groupCounter                      (enq_gc),
    .enq_vd                                (enq_vd),
    .enq_data                              (enq_data),
    .enq_mask                              (enq_mask),
    .enq_instructionIndex                  (enq_idx),
    .enq_last                              (enq_last),
    .vrfWriteRequest_ready                 (rd_ready),
    .vrfWriteRequest_valid                 (out_valid),
    .vrfWriteRequest_bits_vd               (out_vd),
    .vrfWriteRequest_bits_offset           (out_off),
    .vrfWriteRequest_bits_mask             (out_mask),
    .vrfWriteRequest_bits_data             (out_data),
    .vrfWriteRequest_bits_last             (out_last),
    .vrfWriteRequest_bits_instructionIndex (out_idx),
    .occupancy                             (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [4:0] vd, input logic [8:0] gc,
                        input logic [31:0] d, input logic [3:0] m, input logic [2:0] ix,
                        input logic l);
    enq_valid[ch]         = v;
    enq_vd[ch*5 +: 5]     = vd;
    enq_gc[ch*9 +: 9]     = gc;
    enq_data[ch*32 +: 32] = d;
    enq_mask[ch*4 +: 4]   = m;
    enq_idx[ch*3 +: 3]    = ix;
    enq_last[ch]          = l;
  endtask

  initial begin
    rst       = 1'b1;
    enq_valid = '0;
    enq_gc    = '0;
    enq_vd    = '0;
    enq_data  = '0;
    enq_mask  = '0;
    enq_idx   = '0;
    enq_last  = '0;
    rd_ready  = 1'b1;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_occ", occ, 0);
    chk("rst_ready", enq_ready, 0);
    chk("rst_data", out_data, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Basic push then pop.
    set_ch(0, 1, 5'd3, 9'h045, 32'hDEADBEEF, 4'hF, 3'd1, 1);
    settle();
    chk("t1_ready", enq_ready, 2'b01);
    tick();
    enq_valid = '0;
    settle();
    chk("t1_valid", out_valid, 1);
    chk("t1_vd", out_vd, 5);
    chk("t1_off", out_off, 5);
    chk("t1_data", out_data, 32'hDEADBEEF);
    chk("t1_occ", occ, 1);
    tick();
    chk("t1_occ_after_pop", occ, 0);
    chk("t1_valid_after_pop", out_valid, 0);

    // vd wrap: 30 + 15 = 45 mod 32 = 13.
    rd_ready = 1'b0;
    set_ch(1, 1, 5'd30, 9'h1E0, 32'h12345678, 4'hF, 3'd2, 1);
    settle();
    chk("t2_ready", enq_ready, 2'b10);
    tick();
    enq_valid = '0;
    settle();
    chk("t2_vd", out_vd, 13);
    chk("t2_off", out_off, 0);
    chk("t2_occ", occ, 1);
    rd_ready = 1'b1;
    tick();
    chk("t2_occ_after_pop", occ, 0);

    // Round-robin alternation with continuous pops.
    set_ch(0, 1, 5'd1, 9'h000, 32'h11111111, 4'hF, 3'd2, 1);
    set_ch(1, 1, 5'd2, 9'h000, 32'h22222222, 4'hF, 3'd3, 1);
    settle();
    for (int i = 0; i < 4; i++) begin
      chk("t3_grant", enq_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) chk("t3_order", out_data, (i % 2 == 1) ? 32'h11111111 : 32'h22222222);
      tick();
    end
    enq_valid = '0;
    settle();
    chk("t3_last_out", out_data, 32'h22222222);
    tick();
    chk("t3_drain", occ, 0);

    // Fill to DEPTH with the sink stalled.
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ch(0, 1, 5'd7, 9'(i), 32'h1000 + 32'(i), 4'hF, 3'd5, 1);
      settle();
      chk("t4_fill_ready", enq_ready, 2'b01);
      tick();
    end
    set_ch(0, 1, 5'd7, 9'd4, 32'h1004, 4'hF, 3'd5, 1);
    settle();
    chk("t4_full_occ", occ, 4);
    chk("t4_full_ready", enq_ready, 2'b00);
    rd_ready = 1'b1;
    settle();
    chk("t4_pop_no_slot", enq_ready, 2'b00);
    chk("t4_head0", out_data, 32'h1000);
    tick();
    rd_ready = 1'b0;
    settle();
    chk("t4_reopen_ready", enq_ready, 2'b01);
    chk("t4_occ3", occ, 3);
    chk("t4_head1", out_data, 32'h1001);
    enq_valid = '0;
    rd_ready  = 1'b1;
    tick();
    tick();
    tick();
    chk("t4_drain", occ, 0);

    // Tail coalescing.
    rd_ready = 1'b0;
    set_ch(0, 1, 5'd1, 9'd2, 32'h0000AAAA, 4'h3, 3'd4, 0);
    settle();
    chk("t5_first_ready", enq_ready, 2'b01);
    tick();
    set_ch(0, 1, 5'd1, 9'd2, 32'hBBBB0000, 4'hC, 3'd4, 0);
    settle();
    chk("t5_merge_ready", enq_ready, 2'b01);
    tick();
    enq_valid = '0;
    settle();
    chk("t5_occ", occ, 1);
    chk("t5_mask", out_mask, 4'hF);
    chk("t5_data", out_data, 32'hBBBBAAAA);
    chk("t5_off", out_off, 2);
    chk("t5_last", out_last, 0);

    // Single entry being popped this cycle: no merge, a fresh push instead.
    rd_ready = 1'b1;
    set_ch(0, 1, 5'd1, 9'd2, 32'hCCCC0000, 4'hC, 3'd4, 1);
    settle();
    chk("t5b_ready", enq_ready, 2'b01);
    tick();
    enq_valid = '0;
    rd_ready  = 1'b0;
    settle();
    chk("t5b_occ", occ, 1);
    chk("t5b_mask", out_mask, 4'hC);
    chk("t5b_data", out_data, 32'hCCCC0000);
    rd_ready = 1'b1;
    tick();
    chk("t5b_drain", occ, 0);

    // Tail marked last: no merge.
    rd_ready = 1'b0;
    set_ch(0, 1, 5'd1, 9'd2, 32'h0000AAAA, 4'h3, 3'd4, 1);
    tick();
    set_ch(0, 1, 5'd1, 9'd2, 32'hBBBB0000, 4'hC, 3'd4, 0);
    tick();
    enq_valid = '0;
    settle();
    chk("t5c_occ", occ, 2);
    chk("t5c_mask", out_mask, 4'h3);
    chk("t5c_data", out_data, 32'h0000AAAA);
    rd_ready = 1'b1;
    tick();
    tick();
    chk("t5c_drain", occ, 0);

    // Asynchronous reset with entries in flight.
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ch(0, 1, 5'd9, 9'd8 + 9'(i), 32'h3000 + 32'(i), 4'hF, 3'd6, 1);
      tick();
    end
    enq_valid = '0;
    settle();
    chk("t6_occ3", occ, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_occ", occ, 0);
    chk("t6_rst_data", out_data, 0);
    tick();
    rst = 1'b0;
    set_ch(0, 1, 5'd2, 9'd0, 32'h00004444, 4'hF, 3'd1, 1);
    tick();
    enq_valid = '0;
    settle();
    chk("t6_post_valid", out_valid, 1);
    chk("t6_post_occ", occ, 1);
    chk("t6_post_data", out_data, 32'h00004444);
    rd_ready = 1'b1;
    tick();
    chk("t6_post_drain", occ, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
